dmem_resp_v: RTL and testbench
==============================

DMEM_RESP_V -- requirements
Module: dmem_resp_v

Interface
REQ-001 Parameter DEPTH, default 64: data memory size in 32-bit words; power of two, 4 to 4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each access; 0 to 15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  load/store request from the datapath.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address (datapath ALUResult).
REQ-008 req_wdata  input  32  store data (datapath WriteData).
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle pulse: response available.
REQ-011 rsp_rdata  output  32  load data (datapath ReadData); valid while rsp_valid=1.
REQ-012 rsp_err  output  1  access rejected; valid while rsp_valid=1.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-014 In IDLE, req_ready SHALL be 1; in BUSY and RESP, it SHALL be 0.
REQ-015 A request SHALL be accepted when req_valid=1 and req_ready=1 at a rising edge; req_we, req_addr and req_wdata SHALL be latched at that edge, and inputs SHALL be ignored until the FSM returns to IDLE.
REQ-016 On acceptance, the FSM SHALL go to BUSY with wait counter = WAIT_CYCLES-1 when WAIT_CYCLES>0, or go directly to RESP when WAIT_CYCLES=0.
REQ-017 In BUSY, the counter SHALL decrement each cycle; at counter 0, the access SHALL be performed and the FSM SHALL go to RESP.
REQ-018 rsp_valid SHALL be 1 for exactly the one cycle spent in RESP; the FSM SHALL then return to IDLE unconditionally.
REQ-019 Latency from the acceptance edge to rsp_valid=1 SHALL be WAIT_CYCLES+1 cycles; throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-020 The word index SHALL be latched_addr[log2(DEPTH)+1:2].
REQ-021 An address >= 4*DEPTH SHALL be out of range: rsp_err=1, rsp_rdata=0, and no write.
REQ-022 A store SHALL commit req_wdata to memory on the edge entering RESP; the store response SHALL carry rsp_rdata=0.
REQ-023 A load SHALL return the word stored at the index, including a store committed on the immediately preceding response.
REQ-024 Outside RESP, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.

Reset
REQ-025 While reset=0, the FSM SHALL be IDLE, the counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset asserted in BUSY SHALL abort the pending access; an uncommitted store SHALL never be written.
REQ-028 After reset release, the first request SHALL be accepted on the first rising edge with req_valid=1.

Configuration
REQ-029 With DMEM_ALIGN_CHECK_EN defined, latched_addr[1:0]!=0 SHALL produce rsp_err=1 and rsp_rdata=0, with the store suppressed.
REQ-030 Without DMEM_ALIGN_CHECK_EN, addr[1:0] SHALL be ignored (access at the truncated word address), and rsp_err SHALL flag only out-of-range addresses.

Verification
REQ-031 Reset mid-operation: store 0xDEADBEEF to 0x10 (WAIT_CYCLES=2), assert reset one cycle after acceptance, release, then load 0x10 -> the result is not 0xDEADBEEF (prior value), with rsp_valid=0 throughout reset.
REQ-032 Store/load timing: store 0x12345678 to 0x08, then load 0x08 -> rsp_valid pulses 3 cycles after each acceptance, the load returns 0x12345678 with rsp_err=0, and req_ready=0 for 3 cycles per request.
REQ-033 Zero wait states: WAIT_CYCLES=0, back-to-back loads with req_valid held high -> rsp_valid on the cycle after each acceptance, and accepts every 2 cycles.
REQ-034 Out of range: DEPTH=64, load 0x100 -> rsp_err=1 and rsp_rdata=0; store 0x100 then load 0x00 -> word 0 unchanged.
REQ-035 Misaligned store 0xAAAA5555 to 0x0A -> with DMEM_ALIGN_CHECK_EN, rsp_err=1 and word 2 unchanged; without it, rsp_err=0 and a load of 0x08 returns 0xAAAA5555.

Source files
------------

// File: rtl/dmem_resp_v.sv
// dmem_resp_v: word-addressed data memory behind a valid/ready request port
// with a fixed number of wait states and a one-cycle response pulse.
// Optional build macro: DMEM_ALIGN_CHECK_EN (rejects non-word-aligned accesses).
module dmem_resp_v #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_commit;
  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [AW-1:0] w_acc_idx;
  logic          w_acc_oor;
  logic          w_acc_bad;
  logic [AW-1:0] w_rsp_idx;
  logic          w_rsp_oor;
  logic          w_rsp_bad;

  assign w_accept = req_valid && req_ready;

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // commit path must see the live request; otherwise it sees the latched one.
  assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_acc_idx   = w_acc_addr[AW+1:2];
  assign w_acc_oor   = |w_acc_addr[31:AW+2];

  assign w_rsp_idx   = r_addr[AW+1:2];
  assign w_rsp_oor   = |r_addr[31:AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_acc_bad = w_acc_oor | (|w_acc_addr[1:0]);
  assign w_rsp_bad = w_rsp_oor | (|r_addr[1:0]);
`else
  // Byte offset is ignored: the access lands on the truncated word address.
  logic w_unused;
  assign w_unused  = ^{w_acc_addr[1:0], r_addr[1:0]};
  assign w_acc_bad = w_acc_oor;
  assign w_rsp_bad = w_rsp_oor;
`endif

  assign w_enter_resp = ((r_state == IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == BUSY) && (r_cnt == 4'd0));

  // Gated by reset so a store pending at reset assertion is never written.
  assign w_commit = reset && w_enter_resp && w_acc_we && !w_acc_bad;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = (WAIT_CYCLES == 0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state; response fields are zero outside RESP
  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (r_state == RESP) begin
      rsp_err = w_rsp_bad;
      if (!r_we && !w_rsp_bad) begin
        rsp_rdata = r_mem[w_rsp_idx];
      end
    end
  end

  // Request latch and wait-state counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Memory array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_resp_v.sv
// Testbench for dmem_resp_v: two instances (WAIT_CYCLES=2 and 0, DEPTH=64)
// checked every cycle against a timeline model plus directed literal checks.
module tb_dmem_resp_v;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_resp_v #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_resp_v #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int wait_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit model_bad(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a >= 32'd256) || (a[1:0] != 2'b00);
`else
    return (a >= 32'd256);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Timeline model: each accepted request occupies WAIT+1 cycles, the last
  // of which is the response cycle; a store commits as that cycle begins.
  int          m_left [2] = '{0, 0};
  logic        m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata[2];
  logic [31:0] m_mem  [2][64];
  bit          m_known[2][64];
  logic [31:0] e_rdata[2];
  logic        e_err  [2];
  bit          e_known[2];

  always @(posedge clk or negedge reset) begin
    int wi;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_left[k] = 0;
      end else begin
        if (m_left[k] > 0) begin
          m_left[k]--;
        end else if (req_valid[k]) begin
          m_we[k]    = req_we[k];
          m_addr[k]  = req_addr[k];
          m_wdata[k] = req_wdata[k];
          m_left[k]  = wait_of(k) + 1;
        end
        if (m_left[k] == 1) begin
          wi         = int'(m_addr[k] >> 2) % 64;
          e_err[k]   = model_bad(m_addr[k]);
          e_rdata[k] = '0;
          e_known[k] = 1'b1;
          if (!e_err[k]) begin
            if (m_we[k]) begin
              m_mem[k][wi]   = m_wdata[k];
              m_known[k][wi] = 1'b1;
            end else begin
              e_rdata[k] = m_mem[k][wi];
              e_known[k] = m_known[k][wi];
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("ready[%0d]", k), 32'(req_ready[k]), 32'(m_left[k] == 0));
      check($sformatf("valid[%0d]", k), 32'(rsp_valid[k]), 32'(m_left[k] == 1));
      if (m_left[k] == 1) begin
        check($sformatf("err[%0d]", k), 32'(rsp_err[k]), 32'(e_err[k]));
        if (e_known[k]) check($sformatf("rdata[%0d]", k), rsp_rdata[k], e_rdata[k]);
      end else begin
        check($sformatf("idle_err[%0d]", k), 32'(rsp_err[k]), 32'd0);
        check($sformatf("idle_rdata[%0d]", k), rsp_rdata[k], 32'd0);
      end
    end
  end

  task automatic issue(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output int low, output logic [31:0] rd, output logic er);
    int guard;
    guard = 0;
    @(posedge clk); #2;
    while (m_left[k] != 0 && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 20) check("idle_timeout", 32'(guard), 32'd0);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    @(posedge clk); #2;
    req_valid[k] = 1'b0;
    lat = 0;
    low = 0;
    rd  = '0;
    er  = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!req_ready[k]) low++;
      if (rsp_valid[k]) begin
        lat = n;
        rd  = rsp_rdata[k];
        er  = rsp_err[k];
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, low, pulses;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = '0;
      req_wdata[k] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready[0]), 32'd1);
    check("rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'd0);
    check("rst_err", 32'(rsp_err[1]), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Store/load timing with two wait states
    issue(0, 1'b1, 32'h08, 32'h12345678, lat, low, rd, er);
    check("st_latency", 32'(lat), 32'd3);
    check("st_ready_low", 32'(low), 32'd3);
    check("st_rdata", rd, 32'd0);
    issue(0, 1'b0, 32'h08, 32'h0, lat, low, rd, er);
    check("ld_latency", 32'(lat), 32'd3);
    check("ld_ready_low", 32'(low), 32'd3);
    check("ld_rdata", rd, 32'h12345678);
    check("ld_err", 32'(er), 32'd0);

    // Zero wait states: response right after acceptance
    issue(1, 1'b1, 32'h04, 32'h00000055, lat, low, rd, er);
    check("w0_latency", 32'(lat), 32'd1);
    check("w0_ready_low", 32'(low), 32'd1);

    // Out of range
    issue(0, 1'b1, 32'h00, 32'hCAFEF00D, lat, low, rd, er);
    issue(0, 1'b0, 32'h100, 32'h0, lat, low, rd, er);
    check("oor_ld_err", 32'(er), 32'd1);
    check("oor_ld_rdata", rd, 32'd0);
    issue(0, 1'b1, 32'h100, 32'h0BADF00D, lat, low, rd, er);
    check("oor_st_err", 32'(er), 32'd1);
    issue(0, 1'b0, 32'h00, 32'h0, lat, low, rd, er);
    check("oor_word0", rd, 32'hCAFEF00D);
    check("oor_word0_err", 32'(er), 32'd0);

    // Misaligned store
    issue(0, 1'b1, 32'h0A, 32'hAAAA5555, lat, low, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_st_err", 32'(er), 32'd1);
`else
    check("mis_st_err", 32'(er), 32'd0);
`endif
    issue(0, 1'b0, 32'h08, 32'h0, lat, low, rd, er);
`ifdef DMEM_ALIGN_CHECK_EN
    check("mis_word2", rd, 32'h12345678);
`else
    check("mis_word2", rd, 32'hAAAA5555);
`endif

    // Reset one cycle after accepting a store aborts it
    issue(0, 1'b1, 32'h10, 32'h11111111, lat, low, rd, er);
    @(posedge clk); #2;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hDEADBEEF;
    @(posedge clk); #2;
    req_valid[0] = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_valid", 32'(rsp_valid[0]), 32'd0);
      check("abort_ready", 32'(req_ready[0]), 32'd1);
    end
    @(posedge clk); #2;
    reset = 1'b1;
    issue(0, 1'b0, 32'h10, 32'h0, lat, low, rd, er);
    check("abort_latency", 32'(lat), 32'd3);
    check("abort_word", rd, 32'h11111111);

    // Zero wait states, req_valid held: one accept every two cycles
    issue(1, 1'b1, 32'h08, 32'h00000077, lat, low, rd, er);
    @(posedge clk); #2;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'h08;
    @(posedge clk);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[1]) pulses++;
    end
    @(posedge clk); #2;
    req_valid[1] = 1'b0;
    check("burst_pulses", 32'(pulses), 32'd4);
    repeat (3) @(posedge clk);
    issue(1, 1'b0, 32'h04, 32'h0, lat, low, rd, er);
    check("w0_ld_rdata", rd, 32'h00000055);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
